// File: rtl/couple_ramp_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : couple_ramp_ctl
//  Description : Holds the two coupling registers (magnitude + phase offset)
//                read by the interleaved-IQ pair coupler. Host updates arrive
//                over a valid/ready handshake. Magnitudes move in linear
//                ramps. A phase change is sequenced as ramp-to-zero, swap
//                phase, ramp-to-target. Every register commit happens at an
//                IQ pair boundary (rising edge with iq sampled low).
//  Revision    : 1.0 - initial release
// ============================================================================
module couple_ramp_ctl #(
    parameter int CW = 18,   // coupling magnitude width (signed)
    parameter int PW = 19    // phase offset width (signed, full turn = 2^PW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iq,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          wr_sel,
    input  logic [CW-1:0] wr_coupling,
    input  logic [PW-1:0] wr_phase,
    input  logic [CW-2:0] ramp_step,
    input  logic          out_coupling_addr,
    output logic [CW-1:0] out_coupling,
    input  logic          out_phase_offset_addr,
    output logic [PW-1:0] out_phase_offset,
    output logic          busy,
    output logic          done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd1;
    localparam logic [2:0] ST_SWAP      = 3'd2;
    localparam logic [2:0] ST_RAMP_UP   = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam logic [CW-1:0] C_MAG_ZERO   = '0;
    localparam logic [PW-1:0] C_PHASE_ZERO = '0;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic [2:0]    state_q,     state_d;
    logic          sel_q,       sel_d;
    logic [CW-1:0] tgt_mag_q,   tgt_mag_d;
    logic [PW-1:0] tgt_phase_q, tgt_phase_d;
    logic [CW-1:0] mag0_q,      mag0_d;
    logic [CW-1:0] mag1_q,      mag1_d;
    logic [PW-1:0] ph0_q,       ph0_d;
    logic [PW-1:0] ph1_q,       ph1_d;

    // ------------------------------------------------------------------------
    // Helper wires
    // ------------------------------------------------------------------------
    logic          w_slot;        // this edge ends a Q cycle
    logic          w_accept;      // handshake completes this edge
    logic [PW-1:0] w_wr_cur_ph;   // active phase of the coupling being written
    logic [CW-1:0] w_cur_mag;     // active magnitude of the latched coupling
    logic [CW-1:0] w_goal;        // 0 while ramping down, target while ramping up
    logic [CW:0]   w_cur_ext;
    logic [CW:0]   w_goal_ext;
    logic [CW:0]   w_diff;        // goal - current, one extra bit so it cannot overflow
    logic [CW:0]   w_abs;
    logic [CW:0]   w_step_ext;
    logic          w_jump;        // remaining distance fits in one step
    logic [CW-1:0] w_stepped;
    logic [CW-1:0] w_next_mag;

    assign w_slot   = ~iq;
    assign w_accept = wr_valid & wr_ready;

    // Phase currently applied to the coupling the host is addressing
    assign w_wr_cur_ph = wr_sel ? ph1_q : ph0_q;

    // ------------------------------------------------------------------------
    // Ramp arithmetic: one step of the selected magnitude toward the goal.
    // The difference is formed in CW+1 bits so the full signed span
    // (e.g. -2^(CW-1) to 2^(CW-1)-1) is representable. When the remaining
    // distance is within one step, or the step is zero, the goal is loaded
    // exactly; otherwise the step is added/subtracted. Because that only
    // happens when |diff| > step, the CW-bit result stays between the
    // current value and the goal and can neither overshoot nor wrap.
    // ------------------------------------------------------------------------
    assign w_cur_mag  = sel_q ? mag1_q : mag0_q;
    assign w_goal     = (state_q == ST_RAMP_DOWN) ? C_MAG_ZERO : tgt_mag_q;
    assign w_cur_ext  = {w_cur_mag[CW-1], w_cur_mag};
    assign w_goal_ext = {w_goal[CW-1], w_goal};
    assign w_diff     = w_goal_ext - w_cur_ext;
    assign w_abs      = w_diff[CW] ? (~w_diff + 1'b1) : w_diff;
    assign w_step_ext = {2'b00, ramp_step};
    assign w_jump     = (ramp_step == '0) || (w_abs <= w_step_ext);
    assign w_stepped  = w_diff[CW] ? (w_cur_mag - {1'b0, ramp_step})
                                   : (w_cur_mag + {1'b0, ramp_step});
    assign w_next_mag = w_jump ? w_goal : w_stepped;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            tgt_mag_q   <= C_MAG_ZERO;
            tgt_phase_q <= C_PHASE_ZERO;
            mag0_q      <= C_MAG_ZERO;
            mag1_q      <= C_MAG_ZERO;
            ph0_q       <= C_PHASE_ZERO;
            ph1_q       <= C_PHASE_ZERO;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            tgt_mag_q   <= tgt_mag_d;
            tgt_phase_q <= tgt_phase_d;
            mag0_q      <= mag0_d;
            mag1_q      <= mag1_d;
            ph0_q       <= ph0_d;
            ph1_q       <= ph1_d;
        end
    end

    // Next-state logic: FSM transitions and slot-aligned register commits
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        tgt_mag_d   = tgt_mag_q;
        tgt_phase_d = tgt_phase_q;
        mag0_d      = mag0_q;
        mag1_d      = mag1_q;
        ph0_d       = ph0_q;
        ph1_d       = ph1_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    sel_d       = wr_sel;
                    tgt_mag_d   = wr_coupling;
                    tgt_phase_d = wr_phase;
                    // A phase change must pass through zero magnitude first
                    if (wr_phase != w_wr_cur_ph) begin
                        state_d = ST_RAMP_DOWN;
                    end else begin
                        state_d = ST_RAMP_UP;
                    end
                end
            end

            ST_RAMP_DOWN: begin
                if (w_slot) begin
                    if (sel_q) begin
                        mag1_d = w_next_mag;
                    end else begin
                        mag0_d = w_next_mag;
                    end
                    if (w_jump) begin
                        state_d = ST_SWAP;
                    end
                end
            end

            ST_SWAP: begin
                // Magnitude is already zero here, so the phase step is invisible
                if (w_slot) begin
                    if (sel_q) begin
                        ph1_d = tgt_phase_q;
                    end else begin
                        ph0_d = tgt_phase_q;
                    end
                    state_d = ST_RAMP_UP;
                end
            end

            ST_RAMP_UP: begin
                if (w_slot) begin
                    if (sel_q) begin
                        mag1_d = w_next_mag;
                    end else begin
                        mag0_d = w_next_mag;
                    end
                    if (w_jump) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state
    always_comb begin
        wr_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE:      wr_ready = 1'b1;
            ST_RAMP_DOWN: busy     = 1'b1;
            ST_SWAP:      busy     = 1'b1;
            ST_RAMP_UP:   busy     = 1'b1;
            ST_DONE:      done     = 1'b1;
            default:      wr_ready = 1'b0;
        endcase
    end

    // Zero-latency read ports for the coupler
    always_comb begin
        out_coupling     = out_coupling_addr     ? mag1_q : mag0_q;
        out_phase_offset = out_phase_offset_addr ? ph1_q  : ph0_q;
    end

endmodule

`default_nettype wire

// File: doc/couple_ramp_ctl.md
Name: couple_ramp_ctl

Overview:
- Owns the two external coupling registers (magnitude plus phase offset) that the interleaved-IQ pair coupler reads through its 1-bit address ports.
- Accepts host updates through a valid/ready handshake and moves magnitudes in linear ramps.
- Sequences phase changes as ramp-to-zero, swap phase, ramp-to-target, so the coupler output never steps abruptly.
- All register commits are aligned to IQ pair boundaries.

Parameters:
- CW, 18, coupling magnitude width (signed).
- PW, 19, phase offset width (signed, full turn = 2^PW).

Ports:
- clk  in  1  system clock, 2x ADC rate.
- rst  in  1  synchronous reset, active-high.
- iq  in  1  interleave strobe shared with the coupler; high = I cycle, low = Q cycle.
- wr_valid  in  1  host update request.
- wr_ready  out  1  controller can accept an update.
- wr_sel  in  1  which coupling (0/1) to update.
- wr_coupling  in  CW  signed target magnitude.
- wr_phase  in  PW  signed target phase offset.
- ramp_step  in  CW-1  unsigned magnitude change per commit slot; 0 = jump immediately.
- out_coupling_addr  in  1  read address from the coupler.
- out_coupling  out  CW  active magnitude at out_coupling_addr, combinational read.
- out_phase_offset_addr  in  1  read address from the coupler.
- out_phase_offset  out  PW  active phase at out_phase_offset_addr, combinational read.
- busy  out  1  update in progress.
- done  out  1  one-cycle pulse when the target is reached.

Behaviour:
- Reset values:
  - Both magnitudes and both phases = 0.
  - wr_ready = 1, busy = 0, done = 0, FSM = IDLE.
  - Reset mid-ramp abandons the update; active registers return to 0 on the same edge.
- Commit slot:
  - A slot is a rising edge where the sampled iq = 0 (end of Q cycle).
  - Active registers change only in slots, so the next I/Q pair sees one consistent value.
- Handshake:
  - Accept on wr_valid & wr_ready. The edge latches sel, target magnitude and target phase.
  - wr_ready = 1 only in IDLE. wr_valid while busy is ignored, not queued.
- FSM:
  - IDLE: on accept, go to RAMP_DOWN if wr_phase differs from the active phase[sel], else go to RAMP_UP. busy=1 from the accept edge.
  - RAMP_DOWN: each slot, move mag[sel] toward 0 by ramp_step. When it reaches 0, go to SWAP.
  - SWAP: at the next slot, phase[sel] <= target phase; mag[sel] stays 0. Then go to RAMP_UP.
  - RAMP_UP: each slot, move mag[sel] toward the target by ramp_step. When equal, go to DONE.
  - DONE: one cycle with done=1 and busy=0 on the following edge. Then IDLE, wr_ready=1.
- Arithmetic:
  - Compute the difference in CW+1 bits (no overflow).
  - If |diff| <= ramp_step, load the target exactly; otherwise add or subtract ramp_step. No overshoot, no wrap.
  - Ramps are signed: a negative target ramps through negative values.
- ramp_step = 0 means each ramp stage completes in one slot (jump).
- Target equal to the current value and phase unchanged: RAMP_UP completes at the first slot; done still pulses.
- The unselected coupling's registers never change during an update.
- Reads are combinational muxes of the active registers, with zero latency from address to data.

Test Plan:
1. Reset, then read both addresses -> out_coupling = 0, out_phase_offset = 0, wr_ready = 1, busy = 0.
2. sel=0, mag=1000, phase=0 (unchanged), step=300 -> mag[0] commits 300, 600, 900, 1000 on four consecutive iq=0 edges; done pulses once; mag[1] stays 0.
3. From mag[0]=1000/phase 0, write phase=0x10000, mag=-500, step=400:
   - mag[0] goes 600, 200, 0.
   - phase[0]=0x10000 in the SWAP slot, with the magnitude still 0.
   - mag[0] goes -400, -500.
   - Phase never changes while the magnitude is nonzero.
4. Issue wr_valid mid-ramp with different data -> ignored; wr_ready = 0; the original target completes unchanged.
5. Assert rst during RAMP_UP -> on the same edge all registers = 0, FSM = IDLE, no done pulse.
6. ramp_step = 0, mag = 131071 (max positive) from -131072 -> jumps in one slot with no overflow; the value changes only on an iq=0 edge, even if wr_valid is accepted on an iq=1 cycle.
